// File: rtl/bits_reduce_pkg.sv
// bits_reduce_pkg
//   Shared types for the streaming bitwise reduction unit.
//   op_e    : bitwise operator encoding as driven on the op input.
//   state_e : control state of the reduction FSM.
package bits_reduce_pkg;

   typedef enum logic [1:0] {
      OP_XOR  = 2'b00,
      OP_AND  = 2'b01,
      OP_OR   = 2'b10,
      OP_XNOR = 2'b11
   } op_e;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_e;

endpackage

// File: rtl/bits_binop.sv
// bits_binop
//   Purely combinational bitwise binary operator, y = a <op> b.
//   Ports:
//     a, b : WIDTH-bit operands
//     op   : operator select (XOR, AND, OR, XNOR)
//     y    : WIDTH-bit result
module bits_binop
   import bits_reduce_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_e              op,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      unique case (op)
         OP_XOR:  y = a ^ b;
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XNOR: y = ~(a ^ b);
      endcase
   end

endmodule

// File: rtl/bits_reduce_accum.sv
// bits_reduce_accum
//   Streaming bitwise reduction: folds each frame of WIDTH-bit beats into one
//   word with the operator sampled on the frame's first beat, then holds the
//   result on a valid/ready output until the consumer takes it.
//   Ports:
//     CLK, ASYNCRESETN      : clock (rising edge), async active-low reset
//     in_valid/in_ready     : input beat handshake
//     in_data, in_last      : input word, final-beat marker
//     op                    : operator, sampled on the first beat only
//     out_valid/out_ready   : result handshake
//     out_data              : reduced word
//     out_count             : beats folded, saturating at MAX_BEATS
//     out_overflow          : frame had more than MAX_BEATS beats
module bits_reduce_accum
   import bits_reduce_pkg::*;
#(
   parameter  int unsigned WIDTH     = 8,
   parameter  int unsigned MAX_BEATS = 16,
   localparam int unsigned CW        = $clog2(MAX_BEATS + 1)
) (
   input  logic             CLK,
   input  logic             ASYNCRESETN,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    out_count,
   output logic             out_overflow
);

   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

   state_e           state_q, state_d;
   logic             started_q;  // low only until the first edge after reset release
   logic             first_q;    // next accepted beat opens a new frame
   logic [WIDTH-1:0] acc_q;
   op_e              op_q;
   logic [CW-1:0]    count_q;
   logic             ovf_q;

   logic             beat_acc;
   logic             out_hs;
   logic [WIDTH-1:0] fold_y;

   assign beat_acc = in_valid && in_ready;
   assign out_hs   = out_valid && out_ready;

   bits_binop #(
      .WIDTH (WIDTH)
   ) u_binop (
      .a  (acc_q),
      .b  (in_data),
      .op (op_q),
      .y  (fold_y)
   );

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state_q <= ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ACCUM: if (beat_acc && in_last) state_d = DONE;
         DONE:  if (out_hs)              state_d = ACCUM;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs, decoded from registered state only so out_ready never
   // reaches in_ready in the same cycle
   // ---------------------------------------------------------------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         ACCUM: in_ready  = started_q;
         DONE:  out_valid = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath: accumulator, latched operator, beat counter, overflow
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         started_q <= 1'b0;
         first_q   <= 1'b1;
         acc_q     <= '0;
         op_q      <= OP_XOR;
         count_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         started_q <= 1'b1;
         if (out_hs) begin
            first_q <= 1'b1;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
         end else if (beat_acc) begin
            first_q <= 1'b0;
            if (first_q) begin
               // First beat seeds the accumulator, so no identity value is needed
               acc_q   <= in_data;
               op_q    <= op_e'(op);
               count_q <= CW'(1);
               ovf_q   <= 1'b0;
            end else begin
               acc_q <= fold_y;
               if (count_q == MAX_CNT) begin
                  ovf_q <= 1'b1;
               end else begin
                  count_q <= count_q + CW'(1);
               end
            end
         end
      end
   end

   assign out_data     = acc_q;
   assign out_count    = count_q;
   assign out_overflow = ovf_q;

endmodule

// File: tb/tb_bits_reduce_accum.sv
module tb_bits_reduce_accum;
   import bits_reduce_pkg::*;

   localparam int unsigned W  = 8;
   localparam int unsigned MB = 4;
   localparam int unsigned CW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          in_last = 1'b0;
   logic [1:0]    op = 2'b00;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_data;
   logic [CW-1:0] out_count;
   logic          out_overflow;

   always #5 clk = ~clk;

   bits_reduce_accum #(
      .WIDTH     (W),
      .MAX_BEATS (MB)
   ) dut (
      .CLK          (clk),
      .ASYNCRESETN  (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .op           (op),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_count    (out_count),
      .out_overflow (out_overflow)
   );

   typedef struct packed {
      logic [7:0] d;
      logic [2:0] c;
      logic       ov;
   } exp_t;

   typedef struct {
      int              n;
      logic [5:0][7:0] d;
      logic [5:0][1:0] o;
      exp_t            e;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[10];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Result monitor: sampled on the falling edge, handshake completes on the next rise
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_result: got data 0x%0h, expected no result", out_data);
         end else begin
            e = sb.pop_front();
            check("out_data", 32'(out_data), 32'(e.d));
            check("out_count", 32'(out_count), 32'(e.c));
            check("out_overflow", 32'(out_overflow), 32'(e.ov));
         end
      end
   end

   // Called 2 time units after a rising edge; returns 2 units after the accepting edge
   task automatic drive_beat(input logic [7:0] d, input logic l, input logic [1:0] o);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      op       = o;
      while (!in_ready && n < 50) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL in_ready_timeout: got 0, expected 1 within 50 cycles");
      end
      @(posedge clk);
      #2;
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input int n, input logic [5:0][7:0] d, input logic [5:0][1:0] o,
                             input bit gaps, input bit push, input exp_t e);
      if (push) sb.push_back(e);
      for (int i = 0; i < n; i++) begin
         drive_beat(d[i], (i == n - 1), o[i]);
         if (gaps && i < n - 1) begin
            // Idle cycle with junk: in_last/in_data must be ignored without in_valid
            in_valid = 1'b0;
            in_last  = 1'b1;
            in_data  = ~d[i];
            op       = ~o[i];
            @(posedge clk);
            #2;
         end
      end
      in_last = 1'b0;
      check("latency_out_valid", 32'(out_valid), 32'd1);
   endtask

   initial begin
      logic [5:0][7:0] d;
      logic [5:0][1:0] o;

      vecs[0] = '{n: 3, d: 48'h000000_AAF00F, o: 12'h000, e: '{d: 8'h55, c: 3'd3, ov: 1'b0}};
      vecs[1] = '{n: 3, d: 48'h000000_0F3CFF, o: 12'h029, e: '{d: 8'h0C, c: 3'd3, ov: 1'b0}};
      vecs[2] = '{n: 1, d: 48'h000000_00005A, o: 12'h003, e: '{d: 8'h5A, c: 3'd1, ov: 1'b0}};
      vecs[3] = '{n: 6, d: 48'h010101_010101, o: 12'h000, e: '{d: 8'h00, c: 3'd4, ov: 1'b1}};
      vecs[4] = '{n: 2, d: 48'h000000_003412, o: 12'h000, e: '{d: 8'h26, c: 3'd2, ov: 1'b0}};
      vecs[5] = '{n: 4, d: 48'h000080_040201, o: 12'h0AA, e: '{d: 8'h87, c: 3'd4, ov: 1'b0}};
      vecs[6] = '{n: 2, d: 48'h000000_00F00F, o: 12'h003, e: '{d: 8'h00, c: 3'd2, ov: 1'b0}};
      vecs[7] = '{n: 3, d: 48'h000000_550FC3, o: 12'h003, e: '{d: 8'h99, c: 3'd3, ov: 1'b0}};
      vecs[8] = '{n: 5, d: 48'h0018FF_3CF0FF, o: 12'h001, e: '{d: 8'h10, c: 3'd4, ov: 1'b1}};
      vecs[9] = '{n: 1, d: 48'h000000_0000C0, o: 12'h002, e: '{d: 8'hC0, c: 3'd1, ov: 1'b0}};

      // Reset state
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_count", 32'(out_count), 32'd0);
      check("rst_out_overflow", 32'(out_overflow), 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      check("rel_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk);
      #2;
      check("rel_in_ready_high", 32'(in_ready), 32'd1);

      // Table-driven frames, every other one with idle gaps between beats
      out_ready = 1'b1;
      for (int v = 0; v < 10; v++) begin
         send_frame(vecs[v].n, vecs[v].d, vecs[v].o, (v % 2) == 1, 1'b1, vecs[v].e);
      end

      // Consumer stall: result held stable, input blocked
      @(posedge clk);
      #2;
      out_ready = 1'b0;
      d = 48'h000000_001881;
      o = 12'h000;
      send_frame(2, d, o, 1'b0, 1'b1, '{d: 8'h99, c: 3'd2, ov: 1'b0});
      for (int i = 0; i < 5; i++) begin
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_out_data", 32'(out_data), 32'h99);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk);
         #2;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #2;
      check("post_hs_in_ready", 32'(in_ready), 32'd1);
      check("post_hs_out_valid", 32'(out_valid), 32'd0);
      // Back-to-back frames
      d = 48'h000000_00F0F0;
      o = 12'h001;
      send_frame(2, d, o, 1'b0, 1'b1, '{d: 8'hF0, c: 3'd2, ov: 1'b0});
      d = 48'h000000_030201;
      o = 12'h002;
      send_frame(3, d, o, 1'b0, 1'b1, '{d: 8'h03, c: 3'd3, ov: 1'b0});

      // Reset mid-frame after two beats
      @(posedge clk);
      #2;
      drive_beat(8'h11, 1'b0, 2'b00);
      drive_beat(8'h22, 1'b0, 2'b00);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_out_count", 32'(out_count), 32'd0);
      check("midrst_out_data", 32'(out_data), 32'd0);
      #1;
      rst_n = 1'b1;
      check("midrst_rel_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk);
      #2;
      check("midrst_rel_in_ready_high", 32'(in_ready), 32'd1);
      d = 48'h000000_003412;
      o = 12'h000;
      send_frame(2, d, o, 1'b0, 1'b1, '{d: 8'h26, c: 3'd2, ov: 1'b0});

      // Reset while a result is pending: it must be dropped
      @(posedge clk);
      #2;
      out_ready = 1'b0;
      d = 48'h000000_000AA0;
      send_frame(2, d, o, 1'b0, 1'b0, '{d: 8'hAA, c: 3'd2, ov: 1'b0});
      rst_n = 1'b0;
      #1;
      check("donerst_out_valid", 32'(out_valid), 32'd0);
      check("donerst_out_data", 32'(out_data), 32'd0);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      d = 48'h000000_0000C3;
      send_frame(1, d, o, 1'b0, 1'b1, '{d: 8'hC3, c: 3'd1, ov: 1'b0});

      repeat (3) @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
